timer_ctrl: RTL and testbench

- Sequencer for a chain of NDIG 4-bit counter digits. The chain forms a programmable interval timer.
- Holds a programmable terminal count and provides start / pause / resume / stop control.
- Supports one-shot and periodic modes.
- Generates the per-digit carry enables (Enext chain) and a one-cycle done pulse.
- Sits above the 4-bit counter stages as the block that enables, clears and terminates them.

---
 rtl/timer_ctrl.sv | 128 ++++++++++++
 tb/tb_timer_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Programmable interval timer sequencer for a chain of NDIG 4-bit counter digits.
// Provides start/pause/resume/stop control, one-shot/periodic modes, carry enables and a done pulse.
module timer_ctrl #(
  parameter  int unsigned NDIG = 4,
  localparam int unsigned W    = 4 * NDIG
) (
  input  logic            CK,
  input  logic            R,
  input  logic            load,
  input  logic [W-1:0]    limit,
  input  logic            mode,
  input  logic            start,
  input  logic            stop,
  output logic [W-1:0]    Cuenta,
  output logic [NDIG-1:0] Enext,
  output logic            busy,
  output logic            done,
  output logic [1:0]      estado
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_cuenta, w_cuenta_nxt;
  logic [W-1:0]    r_lim, w_lim_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [NDIG-1:0] w_enext;
  logic [NDIG:0]   w_cin;
  logic            w_chain;
  logic [W-1:0]    w_inc;

  // Carry enables: digit i rolls over into i+1 when digits 0..i are all F while running.
  always_comb begin
    w_enext = '0;
    w_chain = (r_state == ST_RUN);
    for (int i = 0; i < int'(NDIG); i++) begin
      w_chain    = w_chain && (r_cuenta[4*i +: 4] == 4'hF);
      w_enext[i] = w_chain;
    end
  end

  // Digit-wise increment: digit 0 always steps, digit i steps on the carry from digit i-1.
  always_comb begin
    w_cin = {w_enext, 1'b1};
    w_inc = r_cuenta;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (w_cin[i]) begin
        w_inc[4*i +: 4] = r_cuenta[4*i +: 4] + 4'd1;
      end
    end
  end

  // Next-state and registered-output logic; priority stop > start > load.
  always_comb begin
    w_state_nxt  = r_state;
    w_cuenta_nxt = r_cuenta;
    w_lim_nxt    = r_lim;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_RUN;
          w_cuenta_nxt = '0;
          w_busy_nxt   = 1'b1;
        end else if (load) begin
          w_lim_nxt = limit;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_PAUSE;
        end else if (r_cuenta == r_lim) begin
          w_done_nxt = 1'b1;
          if (mode) begin
            w_cuenta_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cuenta_nxt = w_inc;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_state_nxt  = ST_IDLE;
          w_cuenta_nxt = '0;
          w_busy_nxt   = 1'b0;
        end else if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (R) begin
      r_state  <= ST_IDLE;
      r_cuenta <= '0;
      r_lim    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cuenta <= w_cuenta_nxt;
      r_lim    <= w_lim_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign Cuenta = r_cuenta;
  assign Enext  = w_enext;
  assign busy   = r_busy;
  assign done   = r_done;
  assign estado = r_state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl (NDIG = 2): vector table plus hand-written multi-cycle sequences.
module tb_timer_ctrl;

  localparam int unsigned NDIG = 2;
  localparam int unsigned W    = 8;
  localparam int unsigned NVEC = 31;

  logic            CK = 1'b0;
  logic            R, load, mode, start, stop;
  logic [W-1:0]    limit;
  logic [W-1:0]    Cuenta;
  logic [NDIG-1:0] Enext;
  logic            busy, done;
  logic [1:0]      estado;

  int n_cmp = 0;
  int n_err = 0;

  timer_ctrl #(.NDIG(NDIG)) dut (
    .CK(CK), .R(R), .load(load), .limit(limit), .mode(mode),
    .start(start), .stop(stop), .Cuenta(Cuenta), .Enext(Enext),
    .busy(busy), .done(done), .estado(estado)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic       r;
    logic       ld;
    logic [7:0] lim;
    logic       md;
    logic       st;
    logic       sp;
    logic [7:0] e_cnt;
    logic [1:0] e_en;
    logic       e_busy;
    logic       e_done;
    logic [1:0] e_st;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_cnt, input logic [1:0] e_en,
                         input logic e_busy, input logic e_done, input logic [1:0] e_st);
    chk($sformatf("%s cuenta", tag), 32'(Cuenta), 32'(e_cnt));
    chk($sformatf("%s enext", tag),  32'(Enext),  32'(e_en));
    chk($sformatf("%s busy", tag),   32'(busy),   32'(e_busy));
    chk($sformatf("%s done", tag),   32'(done),   32'(e_done));
    chk($sformatf("%s estado", tag), 32'(estado), 32'(e_st));
  endtask

  task automatic drive(input logic r, input logic ld, input logic [7:0] lim,
                       input logic md, input logic st, input logic sp);
    R = r; load = ld; limit = lim; mode = md; start = st; stop = sp;
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int n;
    int last_done;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // {R, load, limit, mode, start, stop} -> {Cuenta, Enext, busy, done, estado}
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 2'b00, 1'b0, 1'b1, 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[10] = '{1'b0, 1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 2'b00, 1'b1, 1'b0, 2'd2};
    tbl[13] = '{1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 2'd2};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 2'b00, 1'b0, 1'b1, 2'd0};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 2'b00, 1'b0, 1'b1, 2'd0};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[23] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 2'b00, 1'b1, 1'b0, 2'd2};
    tbl[24] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[26] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 2'd0};
    tbl[27] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 2'd1};
    tbl[28] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 2'd1};
    tbl[29] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 2'd1};
    tbl[30] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 2'd0};

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(tbl[i].r, tbl[i].ld, tbl[i].lim, tbl[i].md, tbl[i].st, tbl[i].sp);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_en, tbl[i].e_busy,
              tbl[i].e_done, tbl[i].e_st);
    end

    // Periodic with carries: lim = 0x11, period 18, Enext[0] only at 0x0F.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0); step();
    chk_all("per start", 8'h00, 2'b00, 1'b1, 1'b0, 2'd1);
    last_done = -1;
    for (int j = 1; j <= 40; j++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step();
      chk_all($sformatf("per j%0d", j), 8'(j % 18), ((j % 18) == 15) ? 2'b01 : 2'b00,
              1'b1, (j % 18) == 0, 2'd1);
      if (done) begin
        if (last_done >= 0) chk("per spacing", 32'(j - last_done), 32'd18);
        last_done = j;
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk_all("per abort", 8'h00, 2'b00, 1'b0, 1'b0, 2'd0);

    // Pause / resume: lim = 10, pause at 4, done 7 edges after resume.
    drive(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (Cuenta != 8'd4 && guard < 20) begin step(); guard++; end
    chk("pr reach4", 32'(guard), 32'd4);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk_all("pr pause", 8'd4, 2'b00, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step();
      chk_all($sformatf("pr hold%0d", j), 8'd4, 2'b00, 1'b1, 1'b0, 2'd2);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    chk_all("pr resume", 8'd4, 2'b00, 1'b1, 1'b0, 2'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    chk("pr resume-to-done", 32'(n), 32'd7);
    chk_all("pr done", 8'd10, 2'b00, 1'b0, 1'b1, 2'd0);

    // Reset mid-run at Cuenta = 5 clears lim as well.
    drive(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (Cuenta != 8'd5 && guard < 20) begin step(); guard++; end
    chk("rst reach5", 32'(guard), 32'd5);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); step();
    chk_all("rst mid", 8'h00, 2'b00, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    chk_all("rst lim0 start", 8'h00, 2'b00, 1'b1, 1'b0, 2'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); step();
    chk_all("rst lim0 done", 8'h00, 2'b00, 1'b0, 1'b1, 2'd0);

    // Full scale: lim = 0xFF, no rollover.
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= 255; j++) begin
      logic [7:0] jv;
      logic [1:0] en;
      step();
      jv = 8'(j);
      en = {jv == 8'hFF, jv[3:0] == 4'hF};
      chk($sformatf("fs cuenta j%0d", j), 32'(Cuenta), 32'(jv));
      chk($sformatf("fs enext j%0d", j),  32'(Enext),  32'(en));
      chk($sformatf("fs done j%0d", j),   32'(done),   32'd0);
    end
    step();
    chk_all("fs done", 8'hFF, 2'b00, 1'b0, 1'b1, 2'd0);
    step();
    chk_all("fs hold", 8'hFF, 2'b00, 1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
